// File: rtl/interval_timer_ctrl_pkg.sv
// Shared encodings for the interval timer controller.
// State and mode constants used by the FSM and the bench.
package interval_timer_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/interval_timer_ctrl_if.sv
// Control/status bundle of the interval timer.
// master drives commands, slave is the timer.
interface interval_timer_ctrl_if #(
  parameter int W = 8
);

  logic         start;
  logic         stop;
  logic         hold;
  logic         mode;
  logic [W-1:0] load_val;
  logic [W-1:0] Q;
  logic         tick;
  logic         busy;
  logic         done;

  modport master (
    output start, stop, hold, mode, load_val,
    input  Q, tick, busy, done
  );

  modport slave (
    input  start, stop, hold, mode, load_val,
    output Q, tick, busy, done
  );

endinterface

// File: rtl/interval_timer_ctrl_cnt4_stage.sv
// 161-style 4-bit synchronous counter slice.
// Load beats count; TC ripples into the next slice's CET.
module cnt4_stage (
  input  logic       CP,
  input  logic       CR,
  input  logic       PE,
  input  logic       CEP,
  input  logic       CET,
  input  logic [3:0] D,
  output logic [3:0] Q,
  output logic       TC
);

  always_ff @(posedge CP) begin
    if (CR) begin
      Q <= 4'h0;
    end else if (!PE) begin
      Q <= D;
    end else if (CEP && CET) begin
      Q <= Q + 4'd1;
    end
  end

  assign TC = (&Q) & CET;

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer: FSM sequencing a cascade of cnt4_stage
// slices, producing a periodic or one-shot tick.
module interval_timer_ctrl
  import interval_timer_ctrl_pkg::*;
#(
  parameter int STAGES = 2
) (
  input logic                  CP,
  input logic                  CR,
  interval_timer_ctrl_if.slave bus
);

  localparam int W = 4 * STAGES;

  state_t         state;
  state_t         state_nx;
  logic [W-1:0]   load_reg;
  logic           mode_reg;
  logic           tick_r;
  logic [W-1:0]   q;
  logic [W-1:0]   d;
  logic [STAGES:0] cet;
  logic           run;
  logic           at_max;
  logic           pe_n;
  logic           cep;
  logic           tick_nx;
  logic           latch_cfg;

  assign run    = (state == S_RUN);
  assign at_max = cet[STAGES];
  assign cet[0] = 1'b1;

  always_ff @(posedge CP) begin
    if (CR) begin
      state    <= S_IDLE;
      load_reg <= '0;
      mode_reg <= MODE_ONESHOT;
      tick_r   <= 1'b0;
    end else begin
      state  <= state_nx;
      tick_r <= tick_nx;
      if (latch_cfg) begin
        load_reg <= bus.load_val;
        mode_reg <= bus.mode;
      end
    end
  end

  // CEP is also dropped at MAX so a one-shot parks on all-ones
  always_comb begin
    state_nx  = state;
    pe_n      = 1'b1;
    d         = load_reg;
    cep       = 1'b0;
    tick_nx   = 1'b0;
    latch_cfg = 1'b0;
    if (bus.stop) begin
      state_nx = S_IDLE;
    end else if (bus.start) begin
      state_nx  = S_RUN;
      pe_n      = 1'b0;
      d         = bus.load_val;
      latch_cfg = 1'b1;
    end else if (run && !bus.hold) begin
      if (at_max) begin
        tick_nx = 1'b1;
        if (mode_reg == MODE_PERIODIC) begin
          pe_n = 1'b0;
        end else begin
          state_nx = S_DONE;
        end
      end else begin
        cep = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cnt4_stage u_stage (
      .CP  (CP),
      .CR  (CR),
      .PE  (pe_n),
      .CEP (cep),
      .CET (cet[k]),
      .D   (d[4*k +: 4]),
      .Q   (q[4*k +: 4]),
      .TC  (cet[k+1])
    );
  end

  assign bus.Q    = q;
  assign bus.tick = tick_r;
  assign bus.busy = run;
  assign bus.done = (state == S_DONE);

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Scenario bench for interval_timer_ctrl: expected outputs are
// queued per applied edge and compared once the edge has settled.
module tb_interval_timer_ctrl;

  typedef struct packed {
    logic [7:0] q;
    logic       tick;
    logic       busy;
    logic       done;
  } obs_t;

  logic CP = 1'b0;
  logic CR = 1'b0;

  interval_timer_ctrl_if #(.W(8)) bus ();

  interval_timer_ctrl #(.STAGES(2)) dut (
    .CP  (CP),
    .CR  (CR),
    .bus (bus)
  );

  always #5 CP = ~CP;

  obs_t exp_q[$];
  obs_t obs_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic obs_t mk(input logic [7:0] q, input logic t,
                              input logic b, input logic dn);
    obs_t r;
    r.q = q; r.tick = t; r.busy = b; r.done = dn;
    return r;
  endfunction

  task automatic apply(input logic cr, input logic st, input logic sp,
                       input logic hd, input logic md,
                       input logic [7:0] lv, input obs_t e);
    obs_t o;
    CR = cr;
    bus.start = st;
    bus.stop = sp;
    bus.hold = hd;
    bus.mode = md;
    bus.load_val = lv;
    exp_q.push_back(e);
    @(posedge CP);
    #1;
    o.q = bus.Q; o.tick = bus.tick; o.busy = bus.busy; o.done = bus.done;
    obs_q.push_back(o);
  endtask

  task automatic idle(input obs_t e);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, e);
  endtask

  task automatic test_reset;
    obs_t e, o;
    int n = 0;
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55, mk(8'h00, 0, 0, 0));
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55, mk(8'h00, 0, 0, 0));
    idle(mk(8'h00, 0, 0, 0));
    idle(mk(8'h00, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++; n++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset[%0d]: got q=%h tick=%b busy=%b done=%b, want q=%h tick=%b busy=%b done=%b",
                 n, o.q, o.tick, o.busy, o.done, e.q, e.tick, e.busy, e.done);
      end
    end
  endtask

  task automatic test_periodic;
    obs_t e, o;
    int n = 0;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFA, mk(8'hFA, 0, 1, 0));
    for (int i = 1; i <= 13; i++)
      idle(mk(8'hFA + 8'(i % 6), (i % 6) == 0, 1, 0));
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, mk(8'hFB, 0, 0, 0));
    idle(mk(8'hFB, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++; n++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL periodic[%0d]: got q=%h tick=%b busy=%b done=%b, want q=%h tick=%b busy=%b done=%b",
                 n, o.q, o.tick, o.busy, o.done, e.q, e.tick, e.busy, e.done);
      end
    end
  endtask

  task automatic test_oneshot;
    obs_t e, o;
    int n = 0;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFD, mk(8'hFD, 0, 1, 0));
    idle(mk(8'hFE, 0, 1, 0));
    idle(mk(8'hFF, 0, 1, 0));
    idle(mk(8'hFF, 1, 0, 1));
    idle(mk(8'hFF, 0, 0, 1));
    idle(mk(8'hFF, 0, 0, 1));
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hF0, mk(8'hF0, 0, 1, 0));
    idle(mk(8'hF1, 0, 1, 0));
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, mk(8'hF1, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++; n++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL oneshot[%0d]: got q=%h tick=%b busy=%b done=%b, want q=%h tick=%b busy=%b done=%b",
                 n, o.q, o.tick, o.busy, o.done, e.q, e.tick, e.busy, e.done);
      end
    end
  endtask

  task automatic test_cascade;
    obs_t e, o;
    int n = 0;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0E, mk(8'h0E, 0, 1, 0));
    idle(mk(8'h0F, 0, 1, 0));
    idle(mk(8'h10, 0, 1, 0));
    idle(mk(8'h11, 0, 1, 0));
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, mk(8'h11, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++; n++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL cascade[%0d]: got q=%h tick=%b busy=%b done=%b, want q=%h tick=%b busy=%b done=%b",
                 n, o.q, o.tick, o.busy, o.done, e.q, e.tick, e.busy, e.done);
      end
    end
  endtask

  task automatic test_hold_terminal;
    obs_t e, o;
    int n = 0;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFE, mk(8'hFE, 0, 1, 0));
    idle(mk(8'hFF, 0, 1, 0));
    for (int i = 0; i < 3; i++)
      apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, mk(8'hFF, 0, 1, 0));
    idle(mk(8'hFE, 1, 1, 0));
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, mk(8'hFE, 0, 1, 0));
    idle(mk(8'hFF, 0, 1, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++; n++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL hold[%0d]: got q=%h tick=%b busy=%b done=%b, want q=%h tick=%b busy=%b done=%b",
                 n, o.q, o.tick, o.busy, o.done, e.q, e.tick, e.busy, e.done);
      end
    end
  endtask

  task automatic test_simultaneous;
    obs_t e, o;
    int n = 0;
    // entered with Q=FF in periodic RUN
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hF8, mk(8'hF8, 0, 1, 0));
    for (int i = 1; i <= 7; i++)
      idle(mk(8'hF8 + 8'(i), 0, 1, 0));
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h20, mk(8'hFF, 0, 0, 0));
    idle(mk(8'hFF, 0, 0, 0));
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h30, mk(8'h30, 0, 1, 0));
    idle(mk(8'h31, 0, 1, 0));
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, mk(8'h00, 0, 0, 0));
    idle(mk(8'h00, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++; n++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL simultaneous[%0d]: got q=%h tick=%b busy=%b done=%b, want q=%h tick=%b busy=%b done=%b",
                 n, o.q, o.tick, o.busy, o.done, e.q, e.tick, e.busy, e.done);
      end
    end
  endtask

  task automatic test_back_to_back;
    obs_t e, o;
    int n = 0;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, mk(8'hFF, 0, 1, 0));
    for (int i = 0; i < 4; i++)
      idle(mk(8'hFF, 1, 1, 0));
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, mk(8'hFF, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++; n++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got q=%h tick=%b busy=%b done=%b, want q=%h tick=%b busy=%b done=%b",
                 n, o.q, o.tick, o.busy, o.done, e.q, e.tick, e.busy, e.done);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.hold = 1'b0;
    bus.mode = 1'b0;
    bus.load_val = 8'h00;
    @(negedge CP);
    test_reset;
    test_periodic;
    test_oneshot;
    test_cascade;
    test_hold_terminal;
    test_simultaneous;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
